// File: rtl/serial_to_parallel_rx.sv
// rtl/serial_to_parallel_rx.sv - serial bit stream to WIDTH-bit word receiver with one-entry output register
module serial_to_parallel_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             msb_first,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] word;
  logic             dir_eff, accept, last_bit, complete, load, drain;

  always_comb begin
    // Direction comes from msb_first only on the first bit; later bits use the latched value.
    dir_eff  = (bit_cnt_q == '0) ? msb_first : dir_q;
    word     = dir_eff ? {shreg_q[WIDTH-2:0], sin} : {sin, shreg_q[WIDTH-1:1]};
    accept   = sin_valid & ~clear;
    last_bit = (bit_cnt_q == CW'(WIDTH - 1));
    complete = accept & last_bit;
    drain    = q_valid_q & q_ready;
    load     = complete & (~q_valid_q | q_ready);

    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    dir_d     = dir_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    overrun_d = overrun_q;

    if (clear) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
      overrun_d = 1'b0;
    end else if (accept) begin
      shreg_d   = word;
      dir_d     = dir_eff;
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + CW'(1);
    end

    if (load) begin
      q_d       = word;
      q_valid_d = 1'b1;
    end else if (drain) begin
      q_valid_d = 1'b0;
    end

    if (complete && !load) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      dir_q     <= 1'b0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      dir_q     <= dir_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign overrun = overrun_q;
  assign busy    = (bit_cnt_q != '0);

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb/tb_serial_to_parallel_rx.sv - directed vector bench for serial_to_parallel_rx
module tb_serial_to_parallel_rx;

  logic       clk;
  logic       reset_n;
  logic       sin;
  logic       sin_valid;
  logic       msb_first;
  logic       clear;
  logic [7:0] q;
  logic       q_valid;
  logic       q_ready;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  serial_to_parallel_rx #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sin      (sin),
    .sin_valid(sin_valid),
    .msb_first(msb_first),
    .clear    (clear),
    .q        (q),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v, s, m, c, r;
    logic [7:0] eq;
    logic       ev, eo, eb;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] prev_q;

  task automatic cyc(input logic v, input logic s, input logic m, input logic c, input logic r);
    sin_valid = v;
    sin       = s;
    msb_first = m;
    clear     = c;
    q_ready   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] eq, input logic ev,
                     input logic eo, input logic eb);
    checks += 4;
    if (q !== eq) begin
      failures++;
      $display("FAIL %s q: got %h want %h", name, q, eq);
    end
    if (q_valid !== ev) begin
      failures++;
      $display("FAIL %s q_valid: got %b want %b", name, q_valid, ev);
    end
    if (overrun !== eo) begin
      failures++;
      $display("FAIL %s overrun: got %b want %b", name, overrun, eo);
    end
    if (busy !== eb) begin
      failures++;
      $display("FAIL %s busy: got %b want %b", name, busy, eb);
    end
  endtask

  function automatic vec_t mk(logic v, logic s, logic m, logic c, logic r,
                              logic [7:0] eq, logic ev, logic eo, logic eb);
    vec_t e;
    e.v = v; e.s = s; e.m = m; e.c = c; e.r = r;
    e.eq = eq; e.ev = ev; e.eo = eo; e.eb = eb;
    return e;
  endfunction

  // seq[7] is the first bit on the wire; msbs gives msb_first per bit slot; q_ready held high.
  task automatic add_word(input logic [7:0] seq, input logic [7:0] msbs, input bit gaps,
                          input logic [7:0] expw);
    for (int i = 0; i < 8; i++) begin
      if (gaps && i > 0)
        for (int g = 0; g < (i % 4); g++)
          tbl.push_back(mk(1'b0, 1'b0, msbs[7-i], 1'b0, 1'b1, prev_q, 1'b0, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, seq[7-i], msbs[7-i], 1'b0, 1'b1,
                       (i == 7) ? expw : prev_q, i == 7, 1'b0, i != 7));
    end
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, expw, 1'b0, 1'b0, 1'b0));
    prev_q = expw;
  endtask

  task automatic send8(input logic [7:0] seq, input logic m, input logic r);
    for (int i = 0; i < 8; i++) cyc(1'b1, seq[7-i], m, 1'b0, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; msb_first = 1'b0; clear = 1'b0; q_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    prev_q = 8'h00;
    add_word(8'b10101000, 8'hFF, 1'b0, 8'hA8);       // MSB-first A8
    add_word(8'b00010101, 8'h00, 1'b0, 8'hA8);       // LSB-first A8
    add_word(8'b11111111, 8'b00011111, 1'b0, 8'hFF); // msb_first toggled after bit 3
    add_word(8'b10101000, 8'b10000000, 1'b0, 8'hA8); // direction latched MSB-first
    add_word(8'b00010101, 8'b01111111, 1'b0, 8'hA8); // direction latched LSB-first
    add_word(8'b01011010, 8'hFF, 1'b1, 8'h5A);       // gapped
    foreach (tbl[k]) begin
      cyc(tbl[k].v, tbl[k].s, tbl[k].m, tbl[k].c, tbl[k].r);
      chk($sformatf("vec%0d", k), tbl[k].eq, tbl[k].ev, tbl[k].eo, tbl[k].eb);
    end

    // Backpressure and overrun
    send8(8'hFF, 1'b1, 1'b0);
    chk("bp_first", 8'hFF, 1'b1, 1'b0, 1'b0);
    send8(8'h0F, 1'b1, 1'b0);
    chk("bp_overrun", 8'hFF, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("bp_drain", 8'hFF, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("bp_clear", 8'hFF, 1'b0, 1'b0, 1'b0);

    // Drain on the same edge as completion
    send8(8'h3C, 1'b1, 1'b0);
    chk("sim_w1", 8'h3C, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, (8'hC3 >> (7 - i)) & 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sim_mid", 8'h3C, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("sim_w2", 8'hC3, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("sim_drain", 8'hC3, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-word
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_pre", 8'hC3, 1'b0, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b1;
    send8(8'b11000101, 1'b1, 1'b1);
    chk("rst_fresh", 8'hC5, 1'b1, 1'b0, 1'b0);

    // clear with sin_valid mid-word; held word untouched
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("clr_pre", 8'hC5, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_mid", 8'hC5, 1'b1, 1'b0, 1'b0);
    send8(8'b00110110, 1'b1, 1'b1);
    chk("clr_fresh", 8'h36, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
